// File: rtl/key_event_scheduler_pkg.sv
// Shared constants for the key event scheduler slice.
//   KEY_N          default number of key lines
//   KEY_IDX_W      default event index width
//   KEY_EVT_DEPTH  default event FIFO depth
//   KEY_OVF_CNT_W  width of the optional overflow counter (KEY_EVT_OVF_CNT_EN)
package key_evt_pkg;

  localparam int unsigned KEY_N         = 4;
  localparam int unsigned KEY_IDX_W     = 2;
  localparam int unsigned KEY_EVT_DEPTH = 4;
  localparam int unsigned KEY_OVF_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [KEY_OVF_CNT_W-1:0] sat_inc(input logic [KEY_OVF_CNT_W-1:0] v);
    return (v == '1) ? v : v + KEY_OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/key_event_scheduler_rr_arbiter.sv
// Round-robin arbiter (module rr_arbiter) used by key_event_scheduler.
//   clk, rst_n  clock, asynchronous active-low reset
//   req         request vector, one bit per key
//   en          grant permitted this cycle
//   grant       one-hot grant (all zero when no grant)
//   grant_idx   index of the granted request
//   grant_vld   a grant is issued this cycle
// After a grant to g the search starts at (g+1) mod N; reset gives key 0 priority.
module rr_arbiter
  import key_evt_pkg::*;
#(
  parameter int unsigned N     = KEY_N,
  parameter int unsigned IDX_W = KEY_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] prio;
  logic [IDX_W-1:0] prio_next;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the keys starting at the priority pointer; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, prio} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      cand_idx = cand[IDX_W-1:0];
      if (en && !grant_vld && req[cand_idx]) begin
        grant_vld       = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    prio_next = '0;
    if (grant_idx != IDX_W'(N-1)) begin
      prio_next = grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= '0;
    end else if (grant_vld) begin
      prio <= prio_next;
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Key event scheduler: latches one-cycle key presses as pending bits, picks one
// pending key per cycle by round-robin and queues its index in an event FIFO.
//   clk, rst_n    clock, asynchronous active-low reset
//   key_pulse     one-cycle press pulses, bit i = key i
//   evt_valid     head-of-FIFO event available
//   evt_ready     consumer accepts the head event when high with evt_valid
//   evt_idx       key index of the head event
//   evt_overflow  one-cycle pulse: a press on an already-pending key was lost
//   ovf_cnt       saturating count of overflow pulses (only with KEY_EVT_OVF_CNT_EN)
//   busy          pending presses or queued events exist
// Optional feature macro: KEY_EVT_OVF_CNT_EN.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int unsigned N     = KEY_N,
  parameter int unsigned IDX_W = KEY_IDX_W,
  parameter int unsigned DEPTH = KEY_EVT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             key_pulse,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [IDX_W-1:0]         evt_idx,
  output logic                     evt_overflow,
`ifdef KEY_EVT_OVF_CNT_EN
  output logic [KEY_OVF_CNT_W-1:0] ovf_cnt,
`endif
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [N-1:0]     pending;
  logic [IDX_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             pop;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             ovf_hit;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Full blocks the grant outright, even if the head is being popped this cycle.
  rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (pending),
    .en        (!full),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign pop       = evt_valid && evt_ready;
  assign evt_valid = !empty;
  assign evt_idx   = mem[rd_ptr[AW-1:0]];
  assign busy      = (|pending) || !empty;

  // A press on a key that is pending and not being granted is coalesced.
  // A press on the key being granted re-arms it (set wins) and is not lost.
  assign ovf_hit = |(key_pulse & pending & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pending      <= (pending & ~grant) | key_pulse;
      evt_overflow <= ovf_hit;
      if (grant_vld) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_vld) begin
      mem[wr_ptr[AW-1:0]] <= grant_idx;
    end
  end

`ifdef KEY_EVT_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (evt_overflow) begin
      ovf_cnt <= sat_inc(ovf_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench for key_event_scheduler: a default instance (N=4, DEPTH=4)
// and an N=8 instance for the full-FIFO case. Per-cycle vectors come from a
// table; multi-cycle sequences use an event scoreboard per instance.
module tb_key_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [3:0] pulse4;
  logic       rdy4;
  logic       v4;
  logic [1:0] idx4;
  logic       ovf4;
  logic       busy4;

  logic [7:0] pulse8;
  logic       rdy8;
  logic       v8;
  logic [2:0] idx8;
  logic       ovf8;
  logic       busy8;

`ifdef KEY_EVT_OVF_CNT_EN
  logic [7:0] cnt4;
  logic [7:0] cnt8;
`endif

  int total = 0;
  int bad   = 0;
  int q4[$];
  int q8[$];
  bit sb4_en = 1'b0;

  always #5 clk = ~clk;

  key_event_scheduler dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_pulse    (pulse4),
    .evt_valid    (v4),
    .evt_ready    (rdy4),
    .evt_idx      (idx4),
    .evt_overflow (ovf4),
`ifdef KEY_EVT_OVF_CNT_EN
    .ovf_cnt      (cnt4),
`endif
    .busy         (busy4)
  );

  key_event_scheduler #(
    .N     (8),
    .IDX_W (3),
    .DEPTH (4)
  ) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_pulse    (pulse8),
    .evt_valid    (v8),
    .evt_ready    (rdy8),
    .evt_idx      (idx8),
    .evt_overflow (ovf8),
`ifdef KEY_EVT_OVF_CNT_EN
    .ovf_cnt      (cnt8),
`endif
    .busy         (busy8)
  );

  typedef struct {
    bit         rst;
    logic [3:0] pulse;
    bit         ready;
    bit         valid;
    logic [1:0] idx;
    bit         ovf;
    bit         busy;
  } vec_t;

  function automatic vec_t mk(bit r, logic [3:0] p, bit rd, bit v, logic [1:0] i, bit o, bit b);
    vec_t t;
    t.rst = r; t.pulse = p; t.ready = rd; t.valid = v; t.idx = i; t.ovf = o; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: handshakes are scoreboarded at the falling edge, then the
  // caller resumes 1 time unit after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (rst_n && sb4_en && v4 && rdy4) begin
      if (q4.size() == 0) check("sb4_extra_event", int'(idx4), -1);
      else                check("sb4_idx", int'(idx4), q4.pop_front());
    end
    if (rst_n && v8 && rdy8) begin
      if (q8.size() == 0) check("sb8_extra_event", int'(idx8), -1);
      else                check("sb8_idx", int'(idx8), q8.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid4", int'(v4), 0);
    check("rst_busy4", int'(busy4), 0);
    check("rst_ovf4", int'(ovf4), 0);
    check("rst_valid8", int'(v8), 0);
    check("rst_busy8", int'(busy8), 0);
    q4.delete();
    q8.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    rst_n  = 1'b0;
    pulse4 = '0;
    rdy4   = 1'b0;
    pulse8 = '0;
    rdy8   = 1'b0;
    #2;

    // single press
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 1, 0, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd2, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 0));
    // simultaneous presses -> 0,1,3
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 1, 0, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd1, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 0));
    // fairness: after key 1, pending 0 and 3 -> 3 first
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 1, 0, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b1001, 1, 1, 2'd1, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 0));
    // press during own grant: set wins, no overflow, key 0 twice
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b0001, 1, 1, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 0));
    // press on pending, non-granted key -> overflow
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 1, 0, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 1, 1, 2'd0, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd1, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 0));
    // three overflows in one cycle -> a single one-cycle pulse
    tbl.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 2'd0, 0, 1));
    tbl.push_back(mk(0, 4'b1110, 1, 1, 2'd0, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd1, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd2, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2'd3, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2'd0, 0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst) begin
        pulse4 = '0;
        do_reset();
      end else begin
        pulse4 = tbl[r].pulse;
        rdy4   = tbl[r].ready;
        cycle();
        check($sformatf("vec%0d_valid", r), int'(v4), int'(tbl[r].valid));
        check($sformatf("vec%0d_ovf", r), int'(ovf4), int'(tbl[r].ovf));
        check($sformatf("vec%0d_busy", r), int'(busy4), int'(tbl[r].busy));
        if (tbl[r].valid) check($sformatf("vec%0d_idx", r), int'(idx4), int'(tbl[r].idx));
      end
    end
    pulse4 = '0;

    // Full FIFO on N=8: keys 0,2,3,5 queued, 6,7 held pending
    do_reset();
    rdy8   = 1'b0;
    pulse8 = 8'b1110_1101;
    q8.push_back(0); q8.push_back(2); q8.push_back(3);
    q8.push_back(5); q8.push_back(6); q8.push_back(7);
    cycle();
    pulse8 = '0;
    repeat (6) cycle();
    check("full_valid", int'(v8), 1);
    check("full_busy", int'(busy8), 1);
    check("full_head", int'(idx8), 0);
    cycle();
    check("full_head_stable", int'(idx8), 0);
    rdy8 = 1'b1;
    for (int k = 0; k < 40 && (q8.size() != 0 || busy8); k++) cycle();
    check("full_events_left", q8.size(), 0);
    check("full_busy_end", int'(busy8), 0);
    repeat (3) cycle();
    rdy8 = 1'b0;

    // Coalesce with full FIFO: second press of key 1 is lost
    do_reset();
    sb4_en = 1'b1;
    rdy4   = 1'b0;
    pulse4 = 4'b1111;
    q4.push_back(0); q4.push_back(1); q4.push_back(2); q4.push_back(3);
    cycle();
    pulse4 = '0;
    repeat (5) cycle();
    check("coal_full_valid", int'(v4), 1);
    check("coal_full_busy", int'(busy4), 1);
    pulse4 = 4'b0010;
    q4.push_back(1);
    cycle();
    check("coal_first_press_ovf", int'(ovf4), 0);
    pulse4 = 4'b0010;
    cycle();
    check("coal_second_press_ovf", int'(ovf4), 1);
    pulse4 = '0;
    cycle();
    check("coal_ovf_one_cycle", int'(ovf4), 0);
`ifdef KEY_EVT_OVF_CNT_EN
    check("coal_ovf_cnt", int'(cnt4), 1);
`endif
    rdy4 = 1'b1;
    for (int k = 0; k < 40 && (q4.size() != 0 || busy4); k++) cycle();
    check("coal_events_left", q4.size(), 0);
    check("coal_busy_end", int'(busy4), 0);
    repeat (3) cycle();

    // Reset mid-run with three queued events
    do_reset();
    rdy4   = 1'b0;
    pulse4 = 4'b0111;
    q4.push_back(0); q4.push_back(1); q4.push_back(2);
    cycle();
    pulse4 = '0;
    repeat (4) cycle();
    check("midrst_valid_before", int'(v4), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_now", int'(v4), 0);
    check("midrst_busy_now", int'(busy4), 0);
    q4.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy4  = 1'b1;
    repeat (6) begin
      cycle();
      check("midrst_no_event", int'(v4), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
